// File: rtl/fifo_read_ctrl.sv
// Read-side controller of the ALU FIFO: derives empty/fill level from the pointers,
// pulses the read counter, and presents words through a registered valid/ready stage.
//
// state | meaning
// IDLE  | output register empty, rd_valid low
// VALID | output register holds a word for the consumer
module fifo_read_ctrl #(
  parameter int MEMORY_DEPTH      = 4,
  parameter int FIFO_ADDRESS_SIZE = $clog2(MEMORY_DEPTH),
  parameter int DATA_WIDTH        = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [FIFO_ADDRESS_SIZE:0]   w_ptr,
  input  logic [FIFO_ADDRESS_SIZE:0]   r_ptr,
  input  logic [DATA_WIDTH-1:0]        mem_rdata,
  input  logic                         rd_ready,
  input  logic                         err_clr,
  output logic                         cr_en,
  output logic                         rd_valid,
  output logic [DATA_WIDTH-1:0]        rd_data,
  output logic                         empty,
  output logic [FIFO_ADDRESS_SIZE:0]   fill_level,
  output logic                         ptr_err
);

  localparam int PW = FIFO_ADDRESS_SIZE + 1;

  typedef enum logic {
    IDLE  = 1'b0,
    VALID = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   rd_data_q, rd_data_d;
  logic                    ptr_err_q, ptr_err_d;
  logic                    load;
  logic                    over;

  // Modular subtraction absorbs the wrap bit, so no explicit MSB handling is needed.
  assign empty      = (w_ptr == r_ptr);
  assign fill_level = w_ptr - r_ptr;
  assign over       = (fill_level > PW'(MEMORY_DEPTH));
  assign load       = !empty && ((state_q == IDLE) || rd_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rd_data_q <= '0;
      ptr_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_data_q <= rd_data_d;
      ptr_err_q <= ptr_err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    rd_data_d = rd_data_q;
    case (state_q)
      IDLE: begin
        if (load) begin
          state_d   = VALID;
          rd_data_d = mem_rdata;
        end
      end
      VALID: begin
        if (rd_ready) begin
          if (load) rd_data_d = mem_rdata;
          else      state_d   = IDLE;
        end
      end
    endcase
  end

  // Setting wins over err_clr so a persisting fault cannot be cleared away.
  always_comb begin
    ptr_err_d = ptr_err_q;
    if (over)         ptr_err_d = 1'b1;
    else if (err_clr) ptr_err_d = 1'b0;
  end

  always_comb begin
    rd_valid = (state_q == VALID);
    cr_en    = load;
    rd_data  = rd_data_q;
    ptr_err  = ptr_err_q;
  end

endmodule

// File: doc/fifo_read_ctrl.md
Name: fifo_read_ctrl

Overview:
Read-side controller of the ALU FIFO, directly downstream of the read-pointer counter.
- Compares the read pointer against the write pointer to derive empty and fill level.
- Generates the counter's read-enable (cr_en).
- Presents FIFO data through a registered valid/ready output stage, so the consumer sees stable data and the read pointer advances only when a word is actually taken from storage.

Parameters:
MEMORY_DEPTH, 4, number of storage words; must be a power of two (pointers wrap at 2*MEMORY_DEPTH).
FIFO_ADDRESS_SIZE, $clog2(MEMORY_DEPTH), memory address width; pointers are FIFO_ADDRESS_SIZE+1 bits.
DATA_WIDTH, 8, width of a FIFO word.

Ports:
clk  input  1  clock, rising edge.
rst_n  input  1  reset, asynchronous, active-low.
w_ptr  input  FIFO_ADDRESS_SIZE+1  write pointer from write-side counter (extra wrap bit in MSB).
r_ptr  input  FIFO_ADDRESS_SIZE+1  read pointer from read-address counter (extra wrap bit in MSB).
mem_rdata  input  DATA_WIDTH  combinational memory read data at address r_ptr[FIFO_ADDRESS_SIZE-1:0].
rd_ready  input  1  consumer accepts rd_data this cycle.
err_clr  input  1  synchronous clear of ptr_err.
cr_en  output  1  read-counter increment enable; one pulse per word loaded into the output stage.
rd_valid  output  1  rd_data holds a valid word.
rd_data  output  DATA_WIDTH  registered output word.
empty  output  1  storage empty (w_ptr == r_ptr); does not include the output register.
fill_level  output  FIFO_ADDRESS_SIZE+1  words in storage = (w_ptr - r_ptr) mod 2^(FIFO_ADDRESS_SIZE+1).
ptr_err  output  1  sticky: pointer distance exceeded MEMORY_DEPTH.

Behaviour:
- Reset (rst_n low, asynchronous): rd_valid=0, rd_data=0, ptr_err=0, FSM=IDLE.
  - cr_en is combinational and is 0 while in IDLE with empty=1.
  - Reset asserted mid-transfer drops rd_valid immediately and discards the held word.
  - The read counter shares rst_n, so pointers return to 0 together.
- Combinational outputs:
  - empty = (w_ptr == r_ptr).
  - fill_level = w_ptr - r_ptr, truncated to pointer width; wrap of the MSB is handled by the modular subtraction.
- load = !empty && (!rd_valid || rd_ready); cr_en = load.
- FSM, two states:
  - IDLE (rd_valid=0): if load, capture rd_data<=mem_rdata and go to VALID; else stay.
  - VALID (rd_valid=1):
    - rd_ready && load: capture next word, stay VALID (back-to-back, one word per cycle).
    - rd_ready && empty: go to IDLE; rd_data holds its last value.
    - !rd_ready: hold rd_data and stay VALID; cr_en=0.
- Latency:
  - A w_ptr increment seen at edge N gives rd_valid=1 after edge N+1, with cr_en high during the cycle between N and N+1.
  - r_ptr advances on the same edge that captures the data.
- Simultaneous write and read on the same edge: fill_level is unchanged; no special case.
- rd_ready while rd_valid=0: ignored, not an error.
- ptr_err:
  - Set on the clock edge when fill_level > MEMORY_DEPTH.
  - Cleared by err_clr only when the error condition is not present that cycle; set has priority.
  - Reads continue normally while ptr_err is set.
- Full detection is the write side's responsibility and is not part of this block.

Test Plan:
1. Reset with w_ptr=r_ptr=0 -> rd_valid=0, rd_data=0x00, cr_en=0, empty=1, fill_level=0, ptr_err=0.
2. Single word: w_ptr 0->1, mem_rdata=0xA5, rd_ready=0 -> cr_en high for 1 cycle; next edge rd_valid=1, rd_data=0xA5, r_ptr=1, empty=1; rd_valid stays 1 until rd_ready=1, then drops.
3. Backpressure then burst: write 4 words 0x11..0x44 with rd_ready=0.
   - Only 0x11 is loaded; fill_level=3 and cr_en=0 while stalled.
   - rd_ready=1 then gives 0x11,0x22,0x33,0x44 on consecutive cycles.
   - rd_valid falls after 0x44; r_ptr=4.
4. Wrap: r_ptr=6, w_ptr=1 -> fill_level=3, empty=0; draining gives r_ptr 6->7->0->1, then empty=1.
5. Pointer error: w_ptr=5, r_ptr=0 -> fill_level=5, ptr_err=1 next edge.
   - err_clr while the condition persists -> ptr_err stays 1.
   - Restore w_ptr=0, then err_clr -> ptr_err=0.
6. Reset mid-operation: rd_valid=1 with rd_data=0x33, drive rst_n low between edges -> rd_valid=0 and rd_data=0x00 without waiting for a clock edge.
